// File: rtl/eprom_table_pkg.sv
// Shared definitions for the EPROM/RAM table writer.
//
// Table layout (one entry = four 4-bit nibbles at {index, offset}):
//   offset 0 : value units     offset 1 : value tens
//   offset 2 : time units      offset 3 : time tens
//
// Optional build macro used by the writer: VERIFY_EN (read-back check).
package eprom_table_pkg;

    localparam logic [1:0] OFF_V_U = 2'd0;
    localparam logic [1:0] OFF_V_T = 2'd1;
    localparam logic [1:0] OFF_T_U = 2'd2;
    localparam logic [1:0] OFF_T_T = 2'd3;

    // Largest value representable as two BCD digits; larger inputs saturate.
    localparam logic [6:0] MAX_BCD = 7'd99;

    typedef enum logic [2:0] {
        IDLE,
        CONV,
        SETUP,
        STROBE,
        HOLD,
        VERIFY,
        ACK
    } state_t;

endpackage

// File: rtl/bin2bcd_99.sv
// Combinational 7-bit binary to two-digit BCD converter with saturation.
//
// Ports:
//   bin     in   7  binary input, any value 0..127
//   tens    out  4  BCD tens digit of min(bin, 99)
//   units   out  4  BCD units digit of min(bin, 99)
//   clamped out  1  high when bin > 99 and the result was saturated
module bin2bcd_99
    import eprom_table_pkg::*;
(
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic       clamped
);

    logic [6:0] sat;

    always_comb begin
        clamped = (bin > MAX_BCD);
        sat     = clamped ? MAX_BCD : bin;
        // Constant divisor: synthesises to a small fixed network.
        tens    = 4'(sat / 7'd10);
        units   = 4'(sat % 7'd10);
    end

endmodule

// File: rtl/eprom_table_writer.sv
// Writer side of the 256x4 EPROM/RAM table interface. Accepts (value, hold-time)
// pairs over a four-phase dav_/rfd handshake, converts each to BCD and writes
// the four nibbles of the entry at {index, offset} with a SETUP/STROBE/HOLD
// cycle per nibble.
//
// Build option: define VERIFY_EN to add a read-back VERIFY phase and the
// sticky err output.
//
// Ports:
//   clock   in     1  system clock, all state on posedge
//   reset_  in     1  asynchronous active-low reset
//   dav_    in     1  data available (active low), v/t valid while low
//   v       in     7  value, binary 0..99 (larger clamps to 99)
//   t       in     7  hold time, binary 0..99 (larger clamps to 99)
//   rfd     out    1  ready for data
//   addr    out    8  RAM address {index, offset}
//   data    inout  4  RAM data bus, driven only during a write access
//   s_      out    1  chip select, active low
//   mw_     out    1  write strobe, active low
//   mr_     out    1  read strobe, active low (constant 1 without VERIFY_EN)
//   full    out    1  sticky, set when the last entry has been written
//   ovf     out    1  sticky, set when an input was clamped
//   err     out    1  (VERIFY_EN only) sticky read-back mismatch flag
module eprom_table_writer
    import eprom_table_pkg::*;
#(
    parameter int unsigned N_ENTRIES     = 64,
    parameter int unsigned STROBE_CYCLES = 1
) (
    input  logic       clock,
    input  logic       reset_,
    input  logic       dav_,
    input  logic [6:0] v,
    input  logic [6:0] t,
    output logic       rfd,
    output logic [7:0] addr,
    inout  wire  [3:0] data,
    output logic       s_,
    output logic       mw_,
    output logic       mr_,
    output logic       full,
    output logic       ovf
`ifdef VERIFY_EN
    ,
    output logic       err
`endif
);

    localparam int unsigned IDX_W = $clog2(N_ENTRIES);

    state_t            state_q, state_d;
    logic [6:0]        v_q, t_q;
    logic [3:0][3:0]   nib_q;
    logic [1:0]        k_q;
    logic [1:0]        scnt_q;
    logic [IDX_W-1:0]  index_q;
    logic              full_q, ovf_q;
    logic              drive;
    logic              strobe_last;
    logic              entry_done;

    logic [3:0]        v_tens, v_units, t_tens, t_units;
    logic              v_clamp, t_clamp;

`ifdef VERIFY_EN
    logic              vph_q;  // 0: first read cycle, 1: sample cycle
    logic              err_q;
`endif

    bin2bcd_99 u_conv_v (
        .bin     (v_q),
        .tens    (v_tens),
        .units   (v_units),
        .clamped (v_clamp)
    );

    bin2bcd_99 u_conv_t (
        .bin     (t_q),
        .tens    (t_tens),
        .units   (t_units),
        .clamped (t_clamp)
    );

    assign strobe_last = (scnt_q == 2'(STROBE_CYCLES - 1));

`ifdef VERIFY_EN
    assign entry_done = (state_q == VERIFY) && vph_q && (k_q == OFF_T_T);
`else
    assign entry_done = (state_q == HOLD) && (k_q == OFF_T_T);
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. dav_ is only looked at in IDLE and ACK, so an early
    // release of dav_ cannot cut a write short.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (!dav_) state_d = CONV;
            CONV:   state_d = SETUP;
            SETUP:  state_d = STROBE;
            STROBE: if (strobe_last) state_d = HOLD;
            HOLD: begin
                if (k_q == OFF_T_T) begin
`ifdef VERIFY_EN
                    state_d = VERIFY;
`else
                    state_d = ACK;
`endif
                end else begin
                    state_d = SETUP;
                end
            end
`ifdef VERIFY_EN
            VERIFY: if (vph_q && (k_q == OFF_T_T)) state_d = ACK;
`endif
            ACK:    if (dav_) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs, decoded from state only.
    always_comb begin
        rfd   = 1'b0;
        s_    = 1'b1;
        mw_   = 1'b1;
        mr_   = 1'b1;
        drive = 1'b0;
        case (state_q)
            IDLE:   rfd = 1'b1;
            SETUP,
            HOLD: begin
                s_    = 1'b0;
                drive = 1'b1;
            end
            STROBE: begin
                s_    = 1'b0;
                mw_   = 1'b0;
                drive = 1'b1;
            end
`ifdef VERIFY_EN
            VERIFY: begin
                s_  = 1'b0;
                mr_ = 1'b0;
            end
`endif
            default: ;
        endcase
    end

    // Datapath: sampled pair, BCD nibbles, counters and sticky flags.
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            v_q     <= '0;
            t_q     <= '0;
            nib_q   <= '0;
            k_q     <= '0;
            scnt_q  <= '0;
            index_q <= '0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef VERIFY_EN
            vph_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (!dav_) begin
                        v_q <= v;
                        t_q <= t;
                    end
                end
                CONV: begin
                    nib_q[OFF_V_U] <= v_units;
                    nib_q[OFF_V_T] <= v_tens;
                    nib_q[OFF_T_U] <= t_units;
                    nib_q[OFF_T_T] <= t_tens;
                    ovf_q          <= ovf_q | v_clamp | t_clamp;
                    k_q            <= '0;
                    scnt_q         <= '0;
                end
                STROBE: scnt_q <= strobe_last ? 2'd0 : scnt_q + 2'd1;
                // Wraps 3 -> 0, which is where VERIFY starts its read-back.
                HOLD:   k_q <= k_q + 2'd1;
`ifdef VERIFY_EN
                VERIFY: begin
                    vph_q <= ~vph_q;
                    if (vph_q) begin
                        if (data != nib_q[k_q]) err_q <= 1'b1;
                        k_q <= k_q + 2'd1;
                    end
                end
`endif
                default: ;
            endcase

            if (entry_done) begin
                if (index_q == IDX_W'(N_ENTRIES - 1)) begin
                    index_q <= '0;
                    full_q  <= 1'b1;
                end else begin
                    index_q <= index_q + 1'b1;
                end
            end
        end
    end

    assign addr = 8'({index_q, k_q});
    assign data = drive ? nib_q[k_q] : 4'bz;
    assign full = full_q;
    assign ovf  = ovf_q;
`ifdef VERIFY_EN
    assign err  = err_q;
`endif

endmodule

// File: tb/tb_eprom_table_writer.sv
module tb_eprom_table_writer;

    localparam int STROBE_CYCLES = 1;
`ifdef VERIFY_EN
    localparam int EXP_LAT = 14 + 8;
`else
    localparam int EXP_LAT = 14;
`endif

    logic       clock = 1'b0;
    logic       reset_ = 1'b0;
    logic       dav_ = 1'b1;
    logic [6:0] v = '0;
    logic [6:0] t = '0;
    logic       rfd;
    logic [7:0] addr;
    wire  [3:0] data;
    logic       s_, mw_, mr_, full, ovf;
`ifdef VERIFY_EN
    logic       err;
`endif

    logic [3:0] ram [256];
    logic       probe_en = 1'b0;
    logic [3:0] probe_val = '0;
    logic       bad_rd = 1'b0;
    logic [3:0] rd_val;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;
    int strobe_viol = 0;

    always #5 clock = ~clock;

    eprom_table_writer #(
        .N_ENTRIES     (64),
        .STROBE_CYCLES (STROBE_CYCLES)
    ) dut (
        .clock  (clock),
        .reset_ (reset_),
        .dav_   (dav_),
        .v      (v),
        .t      (t),
        .rfd    (rfd),
        .addr   (addr),
        .data   (data),
        .s_     (s_),
        .mw_    (mw_),
        .mr_    (mr_),
        .full   (full),
        .ovf    (ovf)
`ifdef VERIFY_EN
        ,
        .err    (err)
`endif
    );

    // RAM model: write on a clock edge with s_ and mw_ low, drive on read.
    always_comb rd_val = (bad_rd && addr[1:0] == 2'd2) ? 4'hF : ram[addr];
    assign data = probe_en ? probe_val : ((!s_ && !mr_) ? rd_val : 4'bz);

    always @(posedge clock) begin
        if (reset_ && !s_ && !mw_) begin
            ram[addr] <= data;
            wr_count  <= wr_count + 1;
        end
    end

    always @(negedge clock) begin
        if (!mw_ && s_) strobe_viol <= strobe_viol + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_ = 1'b0;
        dav_   = 1'b1;
        @(negedge clock);
        reset_ = 1'b1;
    endtask

    // Data bus released: a probe pattern and its complement must read back intact.
    task automatic check_released(input string tag);
        probe_en  = 1'b1;
        probe_val = 4'hA;
        #1 check({tag, "_busA"}, {28'd0, data}, 32'hA);
        probe_val = 4'h5;
        #1 check({tag, "_bus5"}, {28'd0, data}, 32'h5);
        probe_en  = 1'b0;
    endtask

    task automatic check_entry(input string tag, input int idx, input logic [6:0] ev,
                               input logic [6:0] et);
        check({tag, "_vu"}, {28'd0, ram[8'(4*idx+0)]}, 32'(ev % 10));
        check({tag, "_vt"}, {28'd0, ram[8'(4*idx+1)]}, 32'(ev / 10));
        check({tag, "_tu"}, {28'd0, ram[8'(4*idx+2)]}, 32'(et % 10));
        check({tag, "_tt"}, {28'd0, ram[8'(4*idx+3)]}, 32'(et / 10));
    endtask

    // One full handshake; checks latency, strobe width and ACK behaviour.
    task automatic send(input logic [6:0] vv, input logic [6:0] tt);
        int  cyc;
        int  mwlow;
        int  wr0;
        bit  seen;
        bit  done;
        @(negedge clock);
        cyc = 0;
        while (!rfd && cyc < 50) begin
            @(negedge clock);
            cyc++;
        end
        v = vv;
        t = tt;
        dav_ = 1'b0;
        cyc = 0; mwlow = 0; seen = 0; done = 0;
        while (!done && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (!mw_) mwlow++;
            if (!s_) seen = 1;
            else if (seen) done = 1;
        end
        check("latency", done ? cyc : -1, EXP_LAT);
        check("mw_low_cycles", mwlow, 4 * STROBE_CYCLES);
        wr0 = wr_count;
        repeat (2) @(posedge clock);
        #1;
        check("rfd_low_in_ack", {31'd0, rfd}, 32'd0);
        check("no_rewrite_in_ack", wr_count - wr0, 0);
        @(negedge clock);
        dav_ = 1'b1;
        @(posedge clock);
        #1;
        check("rfd_after_release", {31'd0, rfd}, 32'd1);
    endtask

    initial begin
        int         cyc;
        logic [6:0] vi, ti;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_rfd", {31'd0, rfd}, 32'd1);
        check("rst_s_", {31'd0, s_}, 32'd1);
        check("rst_mw_", {31'd0, mw_}, 32'd1);
        check("rst_mr_", {31'd0, mr_}, 32'd1);
        check("rst_addr", {24'd0, addr}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
`ifdef VERIFY_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        check_released("rst");
        @(negedge clock);
        reset_ = 1'b1;

        // First pair: 45 / 12 -> 5,4,2,1 at addr 0..3.
        send(7'd45, 7'd12);
        check("p1_a0", {28'd0, ram[0]}, 32'd5);
        check("p1_a1", {28'd0, ram[1]}, 32'd4);
        check("p1_a2", {28'd0, ram[2]}, 32'd2);
        check("p1_a3", {28'd0, ram[3]}, 32'd1);
        check_released("p1");

        // Full table of 64 entries.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            vi = 7'(((i + 1) % 10) * 11);
            ti = 7'(((i % 9) + 1) * 10 + (i % 10));
            send(vi, ti);
            if (i == 62) check("full_before_last", {31'd0, full}, 32'd0);
        end
        check("full_after_last", {31'd0, full}, 32'd1);
        check("ovf_table", {31'd0, ovf}, 32'd0);
        for (int i = 0; i < 64; i++) begin
            check_entry("table", i, 7'(((i + 1) % 10) * 11), 7'(((i % 9) + 1) * 10 + (i % 10)));
        end

        // 65th pair wraps to index 0; full stays set.
        send(7'd7, 7'd3);
        check("wrap_a0", {28'd0, ram[0]}, 32'd7);
        check("wrap_a1", {28'd0, ram[1]}, 32'd0);
        check("wrap_a2", {28'd0, ram[2]}, 32'd3);
        check("wrap_a3", {28'd0, ram[3]}, 32'd0);
        check("wrap_full", {31'd0, full}, 32'd1);

        // Clamp: 120 -> 99 and ovf, sticky across a following valid pair.
        send(7'd120, 7'd99);
        check("clamp_a4", {28'd0, ram[4]}, 32'd9);
        check("clamp_a5", {28'd0, ram[5]}, 32'd9);
        check("clamp_a6", {28'd0, ram[6]}, 32'd9);
        check("clamp_a7", {28'd0, ram[7]}, 32'd9);
        check("clamp_ovf", {31'd0, ovf}, 32'd1);
        send(7'd10, 7'd20);
        check_entry("after_clamp", 2, 7'd10, 7'd20);
        check("ovf_sticky", {31'd0, ovf}, 32'd1);

        // Reset during the strobe of entry 2.
        do_reset();
        check("rst2_ovf", {31'd0, ovf}, 32'd0);
        check("rst2_full", {31'd0, full}, 32'd0);
        send(7'd11, 7'd22);
        send(7'd55, 7'd66);
        @(negedge clock);
        v = 7'd77;
        t = 7'd88;
        dav_ = 1'b0;
        cyc = 0;
        while (mw_ && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check("reached_strobe", {31'd0, mw_}, 32'd0);
        check("strobe_addr", {24'd0, addr}, 32'd8);
        #2 reset_ = 1'b0;
        #1;
        check("abort_s_", {31'd0, s_}, 32'd1);
        check("abort_mw_", {31'd0, mw_}, 32'd1);
        check("abort_rfd", {31'd0, rfd}, 32'd1);
        check("abort_addr", {24'd0, addr}, 32'd0);
        check_released("abort");
        @(negedge clock);
        dav_ = 1'b1;
        reset_ = 1'b1;
        send(7'd33, 7'd44);
        check_entry("after_abort", 0, 7'd33, 7'd44);

`ifdef VERIFY_EN
        // Read-back: clean RAM keeps err low, a corrupted offset 2 sets it.
        do_reset();
        send(7'd45, 7'd12);
        check("verify_clean", {31'd0, err}, 32'd0);
        bad_rd = 1'b1;
        send(7'd1, 7'd2);
        check("verify_bad", {31'd0, err}, 32'd1);
        bad_rd = 1'b0;
        send(7'd3, 7'd4);
        check("verify_sticky", {31'd0, err}, 32'd1);
        do_reset();
        check("verify_rst", {31'd0, err}, 32'd0);
`endif

        check("strobe_with_select", strobe_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
